t04_wb_responder: RTL

T04_WB_RESPONDER -- requirements
Module: t04_wb_responder

---
 rtl/t04_wb_pkg.sv | 13 +
 rtl/t04_wb_regfile.sv | 34 +++
 rtl/t04_wb_responder.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/t04_wb_pkg.sv
// Shared types and constants for the t04 Wishbone responder slice.
// Holds the responder FSM state encoding and the out-of-range read pattern.
package t04_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } wbState_e;

  localparam logic [31:0] WB_BAD_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/t04_wb_regfile.sv
// Byte-enabled word storage with synchronous clear.
// Read is combinational so the responder can register it into DAT_O.
module t04_wb_regfile #(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [3:0]               sel,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  // Reset has priority, so a write coincident with reset never lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (sel[b]) begin
          mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/t04_wb_responder.sv
// Wishbone classic slave: fixed wait states, byte-enabled RAM window at BASE_ADDR,
// out-of-range accesses acked with writes dropped and reads returning WB_BAD_DATA.
module t04_wb_responder
  import t04_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h3300_0000,
  parameter int          DEPTH       = 64,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [31:0] ADR_I,
  input  logic [31:0] DAT_I,
  input  logic [3:0]  SEL_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O
);

  localparam int          IDXW      = $clog2(DEPTH);
  localparam logic [32:0] LAST_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH) - 33'd1;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  wbState_e    state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic        ackO_q, ackO_d;
  logic [31:0] datO_q, datO_d;

  logic            req;
  logic [31:0]     curAdr;
  logic            curWe;
  logic            inRange;
  logic [31:0]     offset;
  logic [IDXW-1:0] idx;
  logic            rfWe;
  logic [31:0]     rfRdata;

  assign req = CYC_I & STB_I;

  // In IDLE the live bus is decoded so a zero-wait read can load DAT_O directly.
  assign curAdr  = (state_q == IDLE) ? ADR_I : adr_q;
  assign curWe   = (state_q == IDLE) ? WE_I  : we_q;
  assign inRange = ({1'b0, curAdr} >= {1'b0, BASE_ADDR}) && ({1'b0, curAdr} <= LAST_ADDR);
  assign offset  = curAdr - BASE_ADDR;
  assign idx     = IDXW'(offset >> 2);
  assign rfWe    = (state_q == ACK) && we_q && inRange && !rst;

  t04_wb_regfile #(
    .DEPTH(DEPTH)
  ) u_regfile (
    .clk  (clk),
    .rst  (rst),
    .we   (rfWe),
    .sel  (sel_q),
    .idx  (idx),
    .wdata(dat_q),
    .rdata(rfRdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          adr_d = ADR_I;
          dat_d = DAT_I;
          sel_d = SEL_I;
          we_d  = WE_I;
          if (WAIT_CYCLES == 0) begin
            state_d = ACK;
          end else begin
            cnt_d   = WAIT_LOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // DAT_O is loaded only on entry to ACK, so it is zero in every other cycle.
  always_comb begin
    ackO_d = (state_d == ACK);
    datO_d = '0;
    if ((state_d == ACK) && !curWe) begin
      datO_d = inRange ? rfRdata : WB_BAD_DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      ackO_q  <= 1'b0;
      datO_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      ackO_q  <= ackO_d;
      datO_q  <= datO_d;
    end
  end

  assign ACK_O = ackO_q;
  assign DAT_O = datO_q;

endmodule
